// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the access-error rule for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // Addresses are widened to 64 bits so one function serves any ADDR_W.
    function automatic logic access_error(
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic [63:0] word_addr,
        input logic [63:0] last_word
    );
        logic bad_align;
        case (size)
            SZ_HALF: bad_align = off[0];
            SZ_WORD: bad_align = (off != 2'b00);
            SZ_RSVD: bad_align = 1'b1;
            default: bad_align = 1'b0;
        endcase
        return bad_align || (word_addr > last_word);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction for loads and lane merging for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Offset 0 is the most significant lane of the word.
    always_comb begin
        lane_byte   = 8'h00;
        lane_half   = 16'h0000;
        load_value  = word;
        merged_word = wdata;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0: lane_byte = word[31:24];
                    2'd1: lane_byte = word[23:16];
                    2'd2: lane_byte = word[15:8];
                    default: lane_byte = word[7:0];
                endcase
                load_value = is_unsigned ? {24'h000000, lane_byte}
                                         : {{24{lane_byte[7]}}, lane_byte};
                case (off)
                    2'd0: merged_word = {wdata[7:0], word[23:0]};
                    2'd1: merged_word = {word[31:24], wdata[7:0], word[15:0]};
                    2'd2: merged_word = {word[31:16], wdata[7:0], word[7:0]};
                    default: merged_word = {word[31:8], wdata[7:0]};
                endcase
            end
            SZ_HALF: begin
                lane_half   = off[1] ? word[15:0] : word[31:16];
                load_value  = is_unsigned ? {16'h0000, lane_half}
                                          : {{16{lane_half[15]}}, lane_half};
                merged_word = off[1] ? {word[31:16], wdata[15:0]}
                                     : {wdata[15:0], word[15:0]};
            end
            default: begin
                load_value  = word;
                merged_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into aligned word accesses,
// doing read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 4);

    lsu_state_t        state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [1:0]        lat_off;
    logic [31:0]       lat_wdata;

    logic [ADDR_W-1:0] word_addr;
    logic              req_err;
    logic [31:0]       load_value;
    logic [31:0]       merged_word;

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign req_err   = access_error(req_size, req_addr[1:0], 64'(word_addr), LAST_WORD);

    // Strobes are gated by reset so a reset cycle can never touch memory.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign mem_read  = (state == ST_READ) && !reset;
    assign mem_write = (state == ST_WRITE) && !reset;

    lsu_lane_align u_lane_align (
        .word        (mem_rdata),
        .off         (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .wdata       (lat_wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_off      <= 2'b00;
            lat_wdata    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_off      <= req_addr[1:0];
                        lat_wdata    <= req_wdata;
                        mem_addr     <= word_addr;
                        resp_rdata   <= 32'h0;
                        resp_err     <= req_err;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_we && req_size == SZ_WORD) begin
                            mem_wdata <= req_wdata;
                            state     <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (lat_we) begin
                        mem_wdata <= merged_word;
                        state     <= ST_WRITE;
                    end else begin
                        resp_rdata <= load_value;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
